// File: rtl/sprite_scheduler.sv
// Shares the single VGA plot port between N sprite renderers: each enabled slot is started
// in index order, its pixels are forwarded through a registered mux, then one shift pulse per frame.
module sprite_scheduler #(
  parameter int N_SPR   = 4,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 255,
  parameter int SETTLE  = 2
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               run,
  input  logic [N_SPR-1:0]   sprite_en,
  input  logic               frame_tick,
  input  logic [N_SPR-1:0]   done_in,
  input  logic [8*N_SPR-1:0] x_in,
  input  logic [7*N_SPR-1:0] y_in,
  input  logic [3*N_SPR-1:0] col_in,
  output logic [N_SPR-1:0]   go_out,
  output logic               shift_out,
  output logic [7:0]         x_vga,
  output logic [6:0]         y_vga,
  output logic [2:0]         colour_vga,
  output logic               plot_vga,
  output logic [IDW-1:0]     active_id,
  output logic               frame_done,
  output logic               err_timeout,
  output logic               err_overrun
);

  // sel must be able to reach N_SPR, which marks the end of a pass
  localparam int SELW = $clog2(N_SPR + 1);
  localparam logic [SELW-1:0] LAST_SEL   = SELW'(N_SPR);
  localparam logic [7:0]      TIMEOUT_CT = 8'(TIMEOUT);
  localparam logic [7:0]      SETTLE_END = 8'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_GO, S_DRAW, S_WAIT_FRAME, S_SHIFT, S_SETTLE
  } state_t;

  state_t          state, state_nxt;
  logic [SELW-1:0] sel, sel_nxt;
  logic [7:0]      tcount, tcount_nxt;
  logic [7:0]      scnt, scnt_nxt;
  logic            pending;
  logic            take_tick, timeout_hit;

  logic             en_sel, done_sel;
  logic [7:0]       x_sel;
  logic [6:0]       y_sel;
  logic [2:0]       col_sel;
  logic [N_SPR-1:0] go_mask;

  always_comb begin
    en_sel   = 1'b0;
    done_sel = 1'b0;
    x_sel    = '0;
    y_sel    = '0;
    col_sel  = '0;
    go_mask  = '0;
    for (int i = 0; i < N_SPR; i++) begin
      if (sel == SELW'(i)) begin
        en_sel     = sprite_en[i];
        done_sel   = done_in[i];
        x_sel      = x_in[8*i +: 8];
        y_sel      = y_in[7*i +: 7];
        col_sel    = col_in[3*i +: 3];
        go_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    tcount_nxt  = tcount;
    scnt_nxt    = scnt;
    take_tick   = 1'b0;
    timeout_hit = 1'b0;
    go_out      = '0;
    shift_out   = 1'b0;
    frame_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (run) begin
          sel_nxt   = '0;
          state_nxt = S_NEXT;
        end
      end
      S_NEXT: begin
        if (sel == LAST_SEL) begin
          frame_done = 1'b1;
          state_nxt  = S_WAIT_FRAME;
        end else if (!en_sel) begin
          sel_nxt = sel + 1'b1;
        end else begin
          state_nxt = S_GO;
        end
      end
      S_GO: begin
        go_out     = go_mask;
        tcount_nxt = '0;
        state_nxt  = S_DRAW;
      end
      S_DRAW: begin
        // done wins over timeout when both happen in the same cycle
        tcount_nxt = tcount + 8'd1;
        if (done_sel) begin
          sel_nxt   = sel + 1'b1;
          state_nxt = S_NEXT;
        end else if (tcount == TIMEOUT_CT) begin
          timeout_hit = 1'b1;
          sel_nxt     = sel + 1'b1;
          state_nxt   = S_NEXT;
        end
      end
      S_WAIT_FRAME: begin
        if (frame_tick || pending) begin
          take_tick = 1'b1;
          state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        shift_out = 1'b1;
        scnt_nxt  = '0;
        state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (scnt == SETTLE_END) begin
          sel_nxt   = '0;
          state_nxt = run ? S_NEXT : S_IDLE;
        end else begin
          scnt_nxt = scnt + 8'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      sel    <= '0;
      tcount <= '0;
      scnt   <= '0;
    end else begin
      state  <= state_nxt;
      sel    <= sel_nxt;
      tcount <= tcount_nxt;
      scnt   <= scnt_nxt;
    end
  end

  // A tick seen outside S_WAIT_FRAME is remembered once; a second one is an overrun
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pending     <= 1'b0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      if (take_tick) begin
        pending <= 1'b0;
      end else if (frame_tick) begin
        pending <= 1'b1;
        if (pending) err_overrun <= 1'b1;
      end
      if (timeout_hit) err_timeout <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_vga      <= '0;
      y_vga      <= '0;
      colour_vga <= '0;
      plot_vga   <= 1'b0;
    end else begin
      plot_vga <= (state == S_DRAW);
      if (state == S_DRAW) begin
        x_vga      <= x_sel;
        y_vga      <= y_sel;
        colour_vga <= col_sel;
      end
    end
  end

  assign active_id = IDW'(sel);

endmodule

// File: tb/tb_sprite_scheduler.sv
// Bench for sprite_scheduler with two behavioural renderers and a pixel scoreboard.
module tb_sprite_scheduler;

  localparam int N   = 2;
  localparam int IDW = 2;
  localparam int TO  = 255;
  localparam int ST  = 2;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           run = 1'b0;
  logic           frame_tick = 1'b0;
  logic [N-1:0]   sprite_en = '0;
  logic [N-1:0]   done_in;
  logic [8*N-1:0] x_in;
  logic [7*N-1:0] y_in;
  logic [3*N-1:0] col_in;
  logic [N-1:0]   go_out;
  logic           shift_out;
  logic [7:0]     x_vga;
  logic [6:0]     y_vga;
  logic [2:0]     colour_vga;
  logic           plot_vga;
  logic [IDW-1:0] active_id;
  logic           frame_done;
  logic           err_timeout;
  logic           err_overrun;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sprite_scheduler #(.N_SPR(N), .IDW(IDW), .TIMEOUT(TO), .SETTLE(ST)) dut (
    .clk(clk), .resetn(resetn), .run(run), .sprite_en(sprite_en),
    .frame_tick(frame_tick), .done_in(done_in), .x_in(x_in), .y_in(y_in),
    .col_in(col_in), .go_out(go_out), .shift_out(shift_out), .x_vga(x_vga),
    .y_vga(y_vga), .colour_vga(colour_vga), .plot_vga(plot_vga),
    .active_id(active_id), .frame_done(frame_done),
    .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  // Renderer model: after go it counts cycles and raises done once the count reaches dlen
  // (dlen 0 = never finishes); done stays high until the next go.
  int unsigned         dlen [N];
  logic [N-1:0][15:0]  rcnt;
  logic [N-1:0]        busy;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy    <= '0;
      done_in <= '0;
      rcnt    <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (go_out[i]) begin
          busy[i]    <= 1'b1;
          rcnt[i]    <= '0;
          done_in[i] <= 1'b0;
        end else if (busy[i]) begin
          rcnt[i] <= rcnt[i] + 16'd1;
          if (32'(rcnt[i]) + 1 == dlen[i]) begin
            done_in[i] <= 1'b1;
            busy[i]    <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    x_in   = '0;
    y_in   = '0;
    col_in = '0;
    for (int i = 0; i < N; i++) begin
      x_in[8*i +: 8]   = 8'(116 + 50*i + int'(rcnt[i]));
      y_in[7*i +: 7]   = 7'(5 + 20*i + int'(rcnt[i]));
      col_in[3*i +: 3] = 3'(1 + i + int'(rcnt[i]));
    end
  end

  logic [17:0] exp_q [$];
  int          go_log [$];
  int          go_cnt [N];
  int          shift_cnt = 0;
  int          fd_cnt = 0;
  int          plot_cnt = 0;
  logic [N-1:0] sb_act = '0;
  int          sb_n [N];

  // Scoreboard: each draw cycle of the active renderer pushes its pixel; the DUT must plot it one cycle later
  task automatic monitor();
    logic [17:0] expv;
    logic [17:0] actv;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        exp_q.delete();
        sb_act = '0;
        continue;
      end
      if (go_out != '0 || shift_out) begin
        n_checks++;
        if ($countones(go_out) > 1 || (shift_out && go_out != '0))
          $display("[TB] FAIL strobe_exclusive: go_out=%b shift_out=%b required one-hot go, never with shift", go_out, shift_out);
        else n_pass++;
      end
      for (int i = 0; i < N; i++) if (go_out[i]) begin go_cnt[i]++; go_log.push_back(i); end
      if (shift_out) shift_cnt++;
      if (frame_done) fd_cnt++;
      if (plot_vga) begin
        plot_cnt++;
        n_checks++;
        actv = {x_vga, y_vga, colour_vga};
        if (exp_q.size() == 0) begin
          $display("[TB] FAIL pixel_unexpected: plotted %h with no pixel expected", actv);
        end else begin
          expv = exp_q.pop_front();
          if (actv !== expv) $display("[TB] FAIL pixel: got %h required %h", actv, expv);
          else n_pass++;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (sb_act[i]) begin
          exp_q.push_back({x_in[8*i +: 8], y_in[7*i +: 7], col_in[3*i +: 3]});
          sb_n[i]++;
          if (done_in[i] || sb_n[i] == TO + 1) sb_act[i] = 1'b0;
        end
        if (go_out[i]) begin
          sb_act[i] = 1'b1;
          sb_n[i] = 0;
        end
      end
    end
  endtask

  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    run = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({go_out, shift_out, plot_vga, frame_done, err_timeout, err_overrun} !== '0)
      $display("[TB] FAIL reset_strobes: got %b required 0", {go_out, shift_out, plot_vga, frame_done, err_timeout, err_overrun});
    else n_pass++;
    n_checks++;
    if ({x_vga, y_vga, colour_vga} !== 18'd0) $display("[TB] FAIL reset_pixel: got %h required 0", {x_vga, y_vga, colour_vga});
    else n_pass++;
    n_checks++;
    if (active_id !== '0) $display("[TB] FAIL reset_active_id: got %0d required 0", active_id);
    else n_pass++;
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    n_checks++;
    if (go_out !== '0 || plot_vga !== 1'b0) $display("[TB] FAIL idle_no_run: go_out=%b plot=%b required 0", go_out, plot_vga);
    else n_pass++;
  endtask

  task automatic test_two_slots();
    int g0, g1, p0, f0, s0, l0, k;
    dlen[0] = 168;
    dlen[1] = 100;
    sprite_en = 2'b11;
    g0 = go_cnt[0]; g1 = go_cnt[1]; p0 = plot_cnt; f0 = fd_cnt; s0 = shift_cnt; l0 = go_log.size();
    run = 1'b1;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (go_out[0]) break; end
    n_checks++;
    if (k == 20) $display("[TB] FAIL go0_timeout: go_out[0] not seen in 20 cycles, required a pulse");
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({x_vga, y_vga, colour_vga, plot_vga} !== {8'd116, 7'd5, 3'd1, 1'b1})
      $display("[TB] FAIL pixel_lag: x=%0d y=%0d col=%0d plot=%b required 116 5 1 1", x_vga, y_vga, colour_vga, plot_vga);
    else n_pass++;
    for (k = 0; k < 600; k++) begin @(negedge clk); if (frame_done) break; end
    n_checks++;
    if (k == 600) $display("[TB] FAIL frame_done_timeout: not seen in 600 cycles");
    else n_pass++;
    n_checks++;
    if (active_id !== IDW'(2)) $display("[TB] FAIL active_id_wait: got %0d required 2", active_id);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (go_cnt[0] - g0 != 1 || go_cnt[1] - g1 != 1 || go_log.size() < l0 + 2)
      $display("[TB] FAIL go_count: got %0d,%0d required 1,1", go_cnt[0] - g0, go_cnt[1] - g1);
    else if (go_log[l0] != 0 || go_log[l0+1] != 1)
      $display("[TB] FAIL go_order: got %0d then %0d required 0 then 1", go_log[l0], go_log[l0+1]);
    else n_pass++;
    n_checks++;
    if (plot_cnt - p0 != 270) $display("[TB] FAIL plot_count: got %0d required 270", plot_cnt - p0);
    else n_pass++;
    n_checks++;
    if (fd_cnt - f0 != 1) $display("[TB] FAIL frame_done_count: got %0d required 1", fd_cnt - f0);
    else n_pass++;
    n_checks++;
    if (err_timeout !== 1'b0 || exp_q.size() != 0)
      $display("[TB] FAIL two_slot_tail: err_timeout=%b leftover=%0d required 0 0", err_timeout, exp_q.size());
    else n_pass++;
    run = 1'b0;
    pulse_tick();
    repeat (12) @(negedge clk);
    n_checks++;
    if (shift_cnt - s0 != 1 || go_cnt[0] - g0 != 1)
      $display("[TB] FAIL shift_then_idle: shifts=%0d go0=%0d required 1 1", shift_cnt - s0, go_cnt[0] - g0);
    else n_pass++;
  endtask

  task automatic test_single_en();
    int g0, g1, s0, k, j;
    dlen[0] = 20;
    sprite_en = 2'b01;
    g0 = go_cnt[0]; g1 = go_cnt[1]; s0 = shift_cnt;
    run = 1'b1;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (go_out[0]) break; end
    for (k = 1; k <= 100; k++) begin @(negedge clk); if (frame_done) break; end
    n_checks++;
    if (k != 23) $display("[TB] FAIL single_en_latency: go->frame_done %0d cycles required 23", k);
    else n_pass++;
    // tick in the very cycle that enters S_WAIT_FRAME: taken next cycle, not an overrun
    frame_tick = 1'b1;
    run = 1'b0;
    for (j = 1; j <= 6; j++) begin @(negedge clk); frame_tick = 1'b0; if (shift_out) break; end
    n_checks++;
    if (j != 2) $display("[TB] FAIL entry_tick_shift: shift after %0d cycles required 2", j);
    else n_pass++;
    repeat (8) @(negedge clk);
    n_checks++;
    if (go_cnt[1] - g1 != 0 || go_cnt[0] - g0 != 1 || shift_cnt - s0 != 1)
      $display("[TB] FAIL single_en_counts: go0=%0d go1=%0d shift=%0d required 1 0 1", go_cnt[0] - g0, go_cnt[1] - g1, shift_cnt - s0);
    else n_pass++;
    n_checks++;
    if (err_overrun !== 1'b0) $display("[TB] FAIL entry_tick_overrun: got %b required 0", err_overrun);
    else n_pass++;
  endtask

  task automatic test_overrun();
    int s0, k;
    dlen[0] = 60;
    dlen[1] = 10;
    sprite_en = 2'b11;
    s0 = shift_cnt;
    run = 1'b1;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (go_out[0]) break; end
    repeat (10) @(negedge clk);
    pulse_tick();
    repeat (5) @(negedge clk);
    n_checks++;
    if (err_overrun !== 1'b0) $display("[TB] FAIL overrun_single_tick: got %b required 0", err_overrun);
    else n_pass++;
    pulse_tick();
    n_checks++;
    if (err_overrun !== 1'b1) $display("[TB] FAIL overrun_second_tick: got %b required 1", err_overrun);
    else n_pass++;
    run = 1'b0;
    for (k = 0; k < 200; k++) begin @(negedge clk); if (frame_done) break; end
    repeat (20) @(negedge clk);
    n_checks++;
    if (shift_cnt - s0 != 1) $display("[TB] FAIL overrun_shift_count: got %0d required 1", shift_cnt - s0);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int p0, k;
    dlen[0] = 10;
    dlen[1] = 0;
    sprite_en = 2'b11;
    p0 = plot_cnt;
    run = 1'b1;
    for (k = 0; k < 100; k++) begin @(negedge clk); if (go_out[1]) break; end
    n_checks++;
    if (k == 100 || err_timeout !== 1'b0) $display("[TB] FAIL timeout_start: go1 wait=%0d err=%b required go1 seen, err 0", k, err_timeout);
    else n_pass++;
    for (k = 1; k <= 400; k++) begin @(negedge clk); if (frame_done) break; end
    n_checks++;
    if (k != 257) $display("[TB] FAIL timeout_latency: go1->frame_done %0d cycles required 257", k);
    else n_pass++;
    n_checks++;
    if (err_timeout !== 1'b1) $display("[TB] FAIL timeout_flag: got %b required 1", err_timeout);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (plot_cnt - p0 != 11 + TO + 1) $display("[TB] FAIL timeout_plots: got %0d required %0d", plot_cnt - p0, 11 + TO + 1);
    else n_pass++;
    run = 1'b0;
    pulse_tick();
    repeat (10) @(negedge clk);
  endtask

  task automatic test_reset_mid_draw();
    int k;
    dlen[0] = 100;
    dlen[1] = 100;
    sprite_en = 2'b11;
    run = 1'b1;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (go_out[0]) break; end
    repeat (5) @(negedge clk);
    n_checks++;
    if (plot_vga !== 1'b1) $display("[TB] FAIL mid_draw_plot: got %b required 1", plot_vga);
    else n_pass++;
    resetn = 1'b0;
    #1;
    n_checks++;
    if ({plot_vga, x_vga, go_out} !== '0) $display("[TB] FAIL async_reset_outputs: plot=%b x=%0d go=%b required 0", plot_vga, x_vga, go_out);
    else n_pass++;
    n_checks++;
    if (err_timeout !== 1'b0 || err_overrun !== 1'b0) $display("[TB] FAIL reset_clears_errors: to=%b ov=%b required 0 0", err_timeout, err_overrun);
    else n_pass++;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    for (k = 0; k < 20; k++) begin @(negedge clk); if (go_out != '0) break; end
    n_checks++;
    if (go_out !== 2'b01) $display("[TB] FAIL restart_slot0: first go_out=%b required 01", go_out);
    else n_pass++;
    run = 1'b0;
  endtask

  initial begin
    dlen[0] = 0;
    dlen[1] = 0;
    go_cnt[0] = 0; go_cnt[1] = 0;
    sb_n[0] = 0; sb_n[1] = 0;
    fork
      monitor();
    join_none
    test_reset();
    test_two_slots();
    test_single_en();
    test_overrun();
    test_timeout();
    test_reset_mid_draw();
    $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
